// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator controller.
package calc_pkg;

    localparam int unsigned RESULT_W = 32;
    localparam int unsigned LED_W    = 4;
    localparam int unsigned OP_W     = 3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4
    } op_e;

    // One-hot indicator; the calculation shares the result lamp.
    function automatic logic [LED_W-1:0] state_led(input state_e s);
        case (s)
            S_A:     return 4'b0001;
            S_B:     return 4'b0010;
            S_OP:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier, one multiplier bit per cycle, W cycles from start to done.
// Bit 0 is folded in on the start edge so done is visible during the W-th cycle.
module seq_mult
    import calc_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_abort,
    input  logic                start,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic                done,
    output logic [RESULT_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [RESULT_W-1:0] r_acc;
    logic [RESULT_W-1:0] r_mcand;
    logic [W-1:0]        r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_run;
    logic                r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_abort) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc    <= b[0] ? RESULT_W'(a) : '0;
                r_mcand  <= RESULT_W'(a) << 1;
                r_mplier <= b >> 1;
                r_cnt    <= CNT_W'(W - 1);
                r_run    <= 1'b1;
            end else if (r_run) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/calc_control.sv
// Calculator controller: operand/opcode entry FSM, ALU and display feed.
// CALC_MUL_EN adds the sequential multiplier; without it opcode 2 is illegal.
module calc_control
    import calc_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [W-1:0]        SW,
    input  logic [OP_W-1:0]     OP_SEL,
    input  logic                BTN_ENTER,
    input  logic                BTN_CLEAR,
    input  logic                DEC_IN,
    output logic [RESULT_W-1:0] BIN_OUT,
    output logic                DEC_TRIGGER,
    output logic [LED_W-1:0]    STATE_LED,
    output logic                BUSY,
    output logic                ERR
);

    state_e              r_state;
    state_e              w_next;
    logic                r_enter_q;
    logic                r_armed;
    logic                w_enter_edge;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [OP_W-1:0]     r_op;
    logic [RESULT_W-1:0] r_result;
    logic                r_err;
    logic [RESULT_W-1:0] r_bin;
    logic                r_dec;
    logic [LED_W-1:0]    r_led;
    logic                r_busy;
    logic [RESULT_W-1:0] w_calc_result;
    logic                w_illegal;
    logic                w_calc_done;

    // r_armed blocks a button already held when reset releases.
    assign w_enter_edge = BTN_ENTER & ~r_enter_q & r_armed;

`ifdef CALC_MUL_EN
    logic                w_mul_start;
    logic                w_mul_done;
    logic [RESULT_W-1:0] w_mul_product;

    assign w_mul_start = (r_state == S_OP) && w_enter_edge && !BTN_CLEAR
                         && (OP_SEL == OP_MUL);
    assign w_calc_done = (r_op == OP_MUL) ? w_mul_done : 1'b1;

    seq_mult #(.W(W)) u_seq_mult (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_abort (BTN_CLEAR),
        .start   (w_mul_start),
        .a       (r_a),
        .b       (r_b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`else
    assign w_calc_done = 1'b1;
`endif

    // ALU result for the latched opcode.
    always_comb begin
        w_calc_result = '0;
        w_illegal     = 1'b0;
        case (r_op)
            OP_ADD:  w_calc_result = RESULT_W'(r_a) + RESULT_W'(r_b);
            OP_SUB:  w_calc_result = RESULT_W'(r_a) - RESULT_W'(r_b);
            OP_AND:  w_calc_result = RESULT_W'(r_a & r_b);
            OP_OR:   w_calc_result = RESULT_W'(r_a | r_b);
`ifdef CALC_MUL_EN
            OP_MUL:  w_calc_result = w_mul_product;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_A:     if (w_enter_edge) w_next = S_B;
            S_B:     if (w_enter_edge) w_next = S_OP;
            S_OP:    if (w_enter_edge) w_next = S_CALC;
            S_CALC:  if (w_calc_done)  w_next = S_RES;
            S_RES:   if (w_enter_edge) w_next = S_A;
            default: w_next = S_A;
        endcase
        if (BTN_CLEAR) begin
            w_next = S_A;
        end
    end

    // Operand/opcode capture, result register and outputs aligned to the next state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_enter_q <= 1'b0;
            r_armed   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_bin     <= '0;
            r_dec     <= 1'b0;
            r_led     <= 4'b0001;
            r_busy    <= 1'b0;
        end else begin
            r_enter_q <= BTN_ENTER;
            r_armed   <= 1'b1;
            if (BTN_CLEAR) begin
                r_a      <= '0;
                r_b      <= '0;
                r_op     <= '0;
                r_result <= '0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    S_A:    if (w_enter_edge) r_a <= SW;
                    S_B:    if (w_enter_edge) r_b <= SW;
                    S_OP:   if (w_enter_edge) r_op <= OP_SEL;
                    S_CALC: if (w_next == S_RES) begin
                        r_result <= w_calc_result;
                        r_err    <= w_illegal;
                    end
                    S_RES:  if (w_enter_edge) r_err <= 1'b0;
                    default: ;
                endcase
            end
            case (w_next)
                S_A, S_B: r_bin <= RESULT_W'(SW);
                S_OP:     r_bin <= RESULT_W'(OP_SEL);
                S_RES:    r_bin <= (r_state == S_CALC) ? w_calc_result : r_result;
                default:  ;
            endcase
            r_dec  <= DEC_IN && (w_next != S_OP);
            r_led  <= state_led(w_next);
            r_busy <= (w_next == S_CALC);
        end
    end

    assign BIN_OUT     = r_bin;
    assign DEC_TRIGGER = r_dec;
    assign STATE_LED   = r_led;
    assign BUSY        = r_busy;
    assign ERR         = r_err;

endmodule

// File: tb/tb_calc_control.sv
// Directed bench for calc_control (W=16) with an expected-result scoreboard.
module tb_calc_control;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic          CLK;
    logic          RESET;
    logic [W-1:0]  SW;
    logic [2:0]    OP_SEL;
    logic          BTN_ENTER;
    logic          BTN_CLEAR;
    logic          DEC_IN;
    logic [31:0]   BIN_OUT;
    logic          DEC_TRIGGER;
    logic [3:0]    STATE_LED;
    logic          BUSY;
    logic          ERR;

    int   n_vec;
    int   n_err;
    exp_t sb[$];

    calc_control #(.W(W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SW          (SW),
        .OP_SEL      (OP_SEL),
        .BTN_ENTER   (BTN_ENTER),
        .BTN_CLEAR   (BTN_CLEAR),
        .DEC_IN      (DEC_IN),
        .BIN_OUT     (BIN_OUT),
        .DEC_TRIGGER (DEC_TRIGGER),
        .STATE_LED   (STATE_LED),
        .BUSY        (BUSY),
        .ERR         (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press();
        BTN_ENTER = 1'b1;
        tick();
        BTN_ENTER = 1'b0;
        tick();
    endtask

    // Full A/B/OP/CALC/RES pass starting in S_A with enter released.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          input logic [31:0] exp_res, input logic exp_err, input int exp_cyc);
        int   n;
        exp_t e;
        SW = a;
        tick();
        check("sw_a", BIN_OUT, 32'(a));
        check("dec_a", 32'(DEC_TRIGGER), 32'(1));
        press();
        check("led_b", 32'(STATE_LED), 32'(4'b0010));
        SW = b;
        tick();
        check("sw_b", BIN_OUT, 32'(b));
        press();
        check("led_op", 32'(STATE_LED), 32'(4'b0100));
        OP_SEL = op;
        tick();
        check("op_echo", BIN_OUT, 32'(op));
        check("dec_op", 32'(DEC_TRIGGER), 32'(0));
        sb.push_back('{res: exp_res, err: exp_err});
        BTN_ENTER = 1'b1;
        tick();
        BTN_ENTER = 1'b0;
        n = 0;
        while (BUSY === 1'b1 && n < 64) begin
            BTN_ENTER = (n == 2);
            n++;
            tick();
        end
        BTN_ENTER = 1'b0;
        check("calc_cycles", 32'(n), 32'(exp_cyc));
        check("led_res", 32'(STATE_LED), 32'(4'b1000));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result", BIN_OUT, e.res);
            check("err", 32'(ERR), 32'(e.err));
        end else begin
            n_vec++;
            n_err++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end
        tick();
        check("no_queue", 32'(STATE_LED), 32'(4'b1000));
        press();
        check("led_back_a", 32'(STATE_LED), 32'(4'b0001));
        check("err_clr", 32'(ERR), 32'(0));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        RESET     = 1'b0;
        SW        = '0;
        OP_SEL    = '0;
        BTN_ENTER = 1'b1;
        BTN_CLEAR = 1'b0;
        DEC_IN    = 1'b1;
        #12;
        check("rst_bin", BIN_OUT, 32'(0));
        check("rst_led", 32'(STATE_LED), 32'(4'b0001));
        check("rst_busy", 32'(BUSY), 32'(0));
        check("rst_err", 32'(ERR), 32'(0));
        check("rst_dec", 32'(DEC_TRIGGER), 32'(0));

        // Enter already held when reset releases must not advance.
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        repeat (3) tick();
        check("held_at_reset", 32'(STATE_LED), 32'(4'b0001));
        BTN_ENTER = 1'b0;
        SW = 16'h1234;
        tick();
        check("sw_follow", BIN_OUT, 32'h0000_1234);

        // Long press counts once.
        BTN_ENTER = 1'b1;
        repeat (20) tick();
        BTN_ENTER = 1'b0;
        tick();
        check("long_press", 32'(STATE_LED), 32'(4'b0010));
        BTN_CLEAR = 1'b1;
        tick();
        BTN_CLEAR = 1'b0;
        check("clear_to_a", 32'(STATE_LED), 32'(4'b0001));

        run_op(16'd99, 16'd1, 3'd0, 32'd100, 1'b0, 1);
        run_op(16'd3, 16'd5, 3'd1, 32'hFFFF_FFFE, 1'b0, 1);
        run_op(16'hF0F0, 16'h3C3C, 3'd3, 32'h0000_3030, 1'b0, 1);
        run_op(16'hF0F0, 16'h3C3C, 3'd4, 32'h0000_FCFC, 1'b0, 1);
        run_op(16'd12, 16'd7, 3'd7, 32'd0, 1'b1, 1);
        run_op(16'hFFFF, 16'hFFFF, 3'd0, 32'h0001_FFFE, 1'b0, 1);

`ifdef CALC_MUL_EN
        run_op(16'hFFFF, 16'hFFFF, 3'd2, 32'hFFFE_0001, 1'b0, 16);
        // Clear with enter in cycle 8 of a multiply.
        SW = 16'd7;
        tick();
        press();
        SW = 16'd9;
        press();
        OP_SEL = 3'd2;
        tick();
        BTN_ENTER = 1'b1;
        tick();
        BTN_ENTER = 1'b0;
        repeat (7) tick();
        check("mul_busy_c8", 32'(BUSY), 32'(1));
        BTN_CLEAR = 1'b1;
        BTN_ENTER = 1'b1;
        tick();
        check("abort_led", 32'(STATE_LED), 32'(4'b0001));
        check("abort_busy", 32'(BUSY), 32'(0));
        check("abort_err", 32'(ERR), 32'(0));
        BTN_CLEAR = 1'b0;
        BTN_ENTER = 1'b0;
        SW = 16'h0077;
        tick();
        check("abort_sw", BIN_OUT, 32'h0000_0077);
        run_op(16'd123, 16'd45, 3'd2, 32'd5535, 1'b0, 16);
`else
        run_op(16'd6, 16'd7, 3'd2, 32'd0, 1'b1, 1);
`endif

        // Clear beats a simultaneous enter in S_B.
        SW = 16'd5;
        tick();
        press();
        check("pre_clr_b", 32'(STATE_LED), 32'(4'b0010));
        BTN_CLEAR = 1'b1;
        BTN_ENTER = 1'b1;
        tick();
        BTN_CLEAR = 1'b0;
        BTN_ENTER = 1'b0;
        check("clr_enter_b", 32'(STATE_LED), 32'(4'b0001));
        tick();

        // Asynchronous reset between edges while in S_B.
        press();
        check("pre_rst_b", 32'(STATE_LED), 32'(4'b0010));
        #3;
        RESET = 1'b0;
        #1;
        check("arst_bin", BIN_OUT, 32'(0));
        check("arst_led", 32'(STATE_LED), 32'(4'b0001));
        check("arst_busy", 32'(BUSY), 32'(0));
        check("arst_err", 32'(ERR), 32'(0));
        check("arst_dec", 32'(DEC_TRIGGER), 32'(0));
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        tick();
        check("post_rst_a", 32'(STATE_LED), 32'(4'b0001));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_control.md
CALC_CONTROL -- requirements
Module: calc_control

Interface
REQ-001 Parameter: W, 16, operand width in bits; legal range 4..16.
REQ-002 The block SHALL have these ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- SW  in  W  operand switches.
- OP_SEL  in  3  operation code.
- BTN_ENTER  in  1  debounced enter button, level.
- BTN_CLEAR  in  1  debounced clear button, level, synchronous.
- DEC_IN  in  1  display-mode switch: 1 = decimal, 0 = hex.
- BIN_OUT  out  32  value feeding the display driver BIN_IN.
- DEC_TRIGGER  out  1  feeds the display driver DEC_TRIGGER.
- STATE_LED  out  4  one-hot state indicator: bit0 S_A, bit1 S_B, bit2 S_OP, bit3 S_RES.
- BUSY  out  1  high while a calculation is in progress.
- ERR  out  1  illegal-operation flag.

Function
REQ-003 The block SHALL detect BTN_ENTER rising edges from a registered previous value; only one edge SHALL count per press, however long it is held.
REQ-004 The FSM SHALL have five states: S_A -> S_B -> S_OP -> S_CALC -> S_RES -> S_A.
- Each arrow except S_CALC->S_RES SHALL be taken on an enter edge.
- S_CALC->S_RES SHALL be taken when the calculation completes.
REQ-005 In S_A and S_B, BIN_OUT SHALL equal SW zero-extended, registered, with one cycle of latency.
- An enter edge in S_A latches SW into A.
- An enter edge in S_B latches SW into B.
REQ-006 In S_OP, BIN_OUT SHALL equal OP_SEL zero-extended.
- An enter edge latches OP_SEL and moves to S_CALC.
REQ-007 Opcodes and results (A and B unsigned):
- 0 ADD: A+B.
- 1 SUB: A-B as 32-bit two's complement.
- 2 MUL: A*B.
- 3 AND: A&B.
- 4 OR: A|B.
- 5..7: illegal; result SHALL be 0 and ERR SHALL be 1.
REQ-008 S_CALC duration:
- Non-MUL opcodes SHALL stay in S_CALC exactly 1 cycle.
- MUL SHALL stay exactly W cycles (shift-add, one multiplier bit per cycle).
- BUSY SHALL be high exactly while in S_CALC.
REQ-009 In S_RES, BIN_OUT SHALL hold the result, valid from the first cycle of S_RES; an enter edge SHALL return to S_A and clear ERR.
REQ-010 Enter edges arriving during S_CALC SHALL be ignored and SHALL NOT be queued.
REQ-011 BTN_CLEAR high SHALL, on the next edge and from any state, force:
- state S_A;
- A, B, result and ERR to 0;
- any running multiply aborted;
- BUSY to 0.
REQ-012 BTN_CLEAR SHALL take priority over a simultaneous enter edge.
REQ-013 DEC_TRIGGER SHALL equal DEC_IN registered (1-cycle latency), except it SHALL be forced to 0 in S_OP.
REQ-014 STATE_LED SHALL be registered and one-hot; it SHALL show bit3 during S_CALC.

Reset
REQ-015 RESET low SHALL immediately, without waiting for a clock edge, set:
- state S_A;
- BIN_OUT 0, DEC_TRIGGER 0, STATE_LED 4'b0001, BUSY 0, ERR 0;
- A, B, opcode, result and the enter-edge register 0.
REQ-016 After RESET deasserts, a BTN_ENTER that is already high SHALL NOT produce an edge.

Configuration
REQ-017 Macro CALC_MUL_EN:
- Defined: MUL is implemented per REQ-007 and REQ-008.
- Undefined: no multiplier logic SHALL be synthesized, and opcode 2 SHALL behave as an illegal opcode (1 cycle in S_CALC, result 0, ERR 1).

Structure
REQ-018 Package calc_pkg SHALL hold:
- the state enum (S_A, S_B, S_OP, S_CALC, S_RES);
- the opcode enum (OP_ADD..OP_OR);
- the constant RESULT_W = 32.
REQ-019 The multiplier SHALL be the sub-module seq_mult, with this interface:
- inputs: start, a, b;
- outputs: done, product;
- asynchronous active-low reset and synchronous abort.
- It SHALL be instantiated only under CALC_MUL_EN.

Verification (W=16)
REQ-020 A=99, B=1, OP=0 -> BIN_OUT=100 on entry to S_RES; BUSY high exactly 1 cycle.
REQ-021 A=3, B=5, OP=1 -> BIN_OUT=32'hFFFFFFFE; ERR=0.
REQ-022 A=16'hFFFF, B=16'hFFFF, OP=2 with CALC_MUL_EN -> BUSY high 16 cycles, then BIN_OUT=32'hFFFE0001.
REQ-023 CLEAR plus enter edge in the same cycle:
- During cycle 8 of a MUL -> next cycle in S_A, BUSY=0, STATE_LED=4'b0001, then BIN_OUT follows SW.
- Simultaneous CLEAR and enter in S_B -> S_A.
REQ-024 Illegal opcode handling:
- OP=7 -> ERR=1, BIN_OUT=0.
- Without CALC_MUL_EN, OP=2 -> ERR=1, BIN_OUT=0, BUSY high 1 cycle.
REQ-025 Reset and hold behaviour:
- RESET low mid-S_B between clock edges -> all outputs at reset values before the next edge.
- BTN_ENTER held high for 20 cycles in S_A -> exactly one transition to S_B.
